seg7_scan_ctrl: RTL

Parametrised, time-multiplexed driver for common-anode 7-segment displays, and the next generation of the team's fixed 8-digit hex scanner. It adds a configurable digit count and scan rate, a tear-free load handshake for the displayed value, per-digit decimal points and blink, optional leading-zero blanking, and 16-level PWM brightness. It sits between the game/score logic and the board's segment and anode pins.

---
 rtl/seg7_scan_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed common-anode 7-segment scanner with tear-free load, blanking and PWM; optional blink via SEG7_BLINK_EN
module seg7_scan_ctrl #(
    parameter int NDIG    = 8,
    parameter int DIV_W   = 17,
    parameter int BLINK_W = 25
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   blink_en,
    input  logic              blank_lz,
    input  logic [3:0]        bright,
    output logic              pending,
    output logic [6:0]        a_to_g,
    output logic [NDIG-1:0]   an,
    output logic              dp
);

    localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [SW-1:0] LAST = SW'(NDIG - 1);

    logic [DIV_W-1:0]  sc;
    logic [SW-1:0]     s;
    logic [4*NDIG-1:0] stg_val, sh_val;
    logic [NDIG-1:0]   stg_dp, sh_dp;
    logic [NDIG-1:0]   stg_blk, sh_blk;

    logic              slot_end, frame_end;
    logic              blink_phase;
    logic [NDIG-1:0]   zero_above;
    logic              zero_acc;
    logic [3:0]        nib;
    logic              lz_blank, pwm_on, lit;
    logic [NDIG-1:0]   sel;

    assign slot_end  = &sc;
    assign frame_end = slot_end && (s == LAST);

    // Slot counter and digit index: a digit owns the display for 2^DIV_W clocks.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sc <= '0;
            s  <= '0;
        end else begin
            sc <= sc + 1'b1;
            if (slot_end)
                s <= (s == LAST) ? '0 : s + 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    logic [BLINK_W-1:0] bcnt;

    // Free-running blink counter; its MSB selects the dark half of the blink period.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            bcnt <= '0;
        else
            bcnt <= bcnt + 1'b1;
    end

    assign blink_phase = bcnt[BLINK_W-1];
`else
    // Blink counter not built; BLINK_W is at least 1, so this is a constant 0.
    assign blink_phase = (BLINK_W == 0);
`endif

    // Staging takes every load; shadow only changes at a frame boundary with no load in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stg_val <= '0;
            stg_dp  <= '0;
            stg_blk <= '0;
            sh_val  <= '0;
            sh_dp   <= '0;
            sh_blk  <= '0;
            pending <= 1'b0;
        end else if (load) begin
            stg_val <= value;
            stg_dp  <= dp_in;
            stg_blk <= blink_en;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            sh_val  <= stg_val;
            sh_dp   <= stg_dp;
            sh_blk  <= stg_blk;
            pending <= 1'b0;
        end
    end

    // zero_above[i] = nibbles i..NDIG-1 of the shadow value are all zero.
    always_comb begin
        zero_above = '0;
        zero_acc   = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_acc      = zero_acc & (sh_val[4*i +: 4] == 4'h0);
            zero_above[i] = zero_acc;
        end
    end

    assign nib      = sh_val[{s, 2'b00} +: 4];
    assign lz_blank = blank_lz && (s != '0) && zero_above[s];
    assign pwm_on   = (sc[DIV_W-1 -: 4] <= bright);
    assign lit      = pwm_on && !lz_blank && !(blink_phase && sh_blk[s]);
    assign sel      = {{(NDIG-1){1'b0}}, 1'b1} << s;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'b1000000;
            4'h1: font = 7'b1111001;
            4'h2: font = 7'b0100100;
            4'h3: font = 7'b0110000;
            4'h4: font = 7'b0011001;
            4'h5: font = 7'b0010010;
            4'h6: font = 7'b0000010;
            4'h7: font = 7'b1111000;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0010000;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b0000011;
            4'hC: font = 7'b1000110;
            4'hD: font = 7'b0100001;
            4'hE: font = 7'b0000110;
            default: font = 7'b0001110;
        endcase
    endfunction

    // Registered pin drive; the segment pattern follows the digit even while its anode is dark.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an     <= '1;
            a_to_g <= 7'b1111111;
            dp     <= 1'b1;
        end else begin
            an     <= ~(sel & {NDIG{lit}});
            a_to_g <= font(nib);
            dp     <= ~(lit && sh_dp[s]);
        end
    end

endmodule
